// File: rtl/lock_entry_sequencer.sv
// Multi-digit combination lock controller: sequences digit entry, checks the
// stored code, manages failed attempts, lockout, alarm and code reprogramming.
module lock_entry_sequencer #(
    parameter int                         DIGITS         = 4,
    parameter int                         DIG_W          = 4,
    parameter logic [DIGITS*DIG_W-1:0]    DEFAULT_CODE   = 16'h6666,
    parameter int                         MAX_TRIES      = 3,
    parameter int                         LOCKOUT_CYCLES = 50000000,
    parameter int                         TIMEOUT_CYCLES = 250000000
) (
    input  logic                           Clock,
    input  logic                           Resetn,
    input  logic [DIG_W-1:0]               switch,
    input  logic                           e_pulse,
    input  logic                           c_pulse,
    output logic                           unlock,
    output logic                           prog_mode,
    output logic                           lockout,
    output logic                           alarm,
    output logic [$clog2(DIGITS)-1:0]      digit_idx,
    output logic [$clog2(MAX_TRIES+1)-1:0] tries_left,
    output logic [0:6]                     leds
);

    localparam int IW  = $clog2(DIGITS);
    localparam int TRW = $clog2(MAX_TRIES + 1);
    localparam int LW  = $clog2(LOCKOUT_CYCLES + 1);
    localparam int TW  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int CW  = DIGITS * DIG_W;

    typedef enum logic [2:0] {
        S_ENTRY   = 3'd0,
        S_OPEN    = 3'd1,
        S_PROGRAM = 3'd2,
        S_LOCKOUT = 3'd3,
        S_ALARM   = 3'd4
    } state_t;

    state_t         state, state_n;
    logic [CW-1:0]  code, code_n;
    logic [CW-1:0]  shadow, shadow_n;
    logic [IW-1:0]  idx, idx_n;
    logic           mismatch, mismatch_n;
    logic [TRW-1:0] tries, tries_n;
    logic [LW-1:0]  lock_tmr, lock_tmr_n;
    logic [TW-1:0]  idle_tmr, idle_tmr_n;
    logic           last_digit;
    logic           dig_ok;

    function automatic logic [0:6] led_pattern(input state_t s);
        case (s)
            S_ENTRY:   return 7'b1111110;
            S_PROGRAM: return 7'b1101010;
            S_OPEN:    return 7'b0000001;
            S_LOCKOUT: return 7'b0110000;
            default:   return 7'b0001000;
        endcase
    endfunction

    assign last_digit = (idx == IW'(DIGITS - 1));
    assign dig_ok     = (code[idx*DIG_W +: DIG_W] == switch);

    always_comb begin
        state_n    = state;
        code_n     = code;
        shadow_n   = shadow;
        idx_n      = idx;
        mismatch_n = mismatch;
        tries_n    = tries;
        lock_tmr_n = lock_tmr;
        idle_tmr_n = idle_tmr;
        case (state)
            S_ENTRY: begin
                // c_pulse has priority over a simultaneous e_pulse everywhere
                if (c_pulse) begin
                    idx_n      = '0;
                    mismatch_n = 1'b0;
                    idle_tmr_n = TW'(TIMEOUT_CYCLES - 1);
                end else if (e_pulse) begin
                    idle_tmr_n = TW'(TIMEOUT_CYCLES - 1);
                    if (last_digit) begin
                        idx_n      = '0;
                        mismatch_n = 1'b0;
                        if (!mismatch && dig_ok) begin
                            state_n = S_OPEN;
                            tries_n = TRW'(MAX_TRIES);
                        end else begin
                            tries_n = (tries != '0) ? tries - TRW'(1) : '0;
                            if (tries_n == '0) begin
                                state_n = S_ALARM;
                            end else begin
                                state_n    = S_LOCKOUT;
                                lock_tmr_n = LW'(LOCKOUT_CYCLES - 1);
                            end
                        end
                    end else begin
                        idx_n      = idx + IW'(1);
                        mismatch_n = mismatch | ~dig_ok;
                    end
                end else if (idx != '0) begin
                    // Idle timeout discards a partial entry without costing a try
                    if (idle_tmr == '0) begin
                        idx_n      = '0;
                        mismatch_n = 1'b0;
                    end else begin
                        idle_tmr_n = idle_tmr - TW'(1);
                    end
                end
            end
            S_OPEN: begin
                if (c_pulse) begin
                    state_n  = S_PROGRAM;
                    idx_n    = '0;
                    shadow_n = '0;
                end else if (e_pulse) begin
                    state_n = S_ENTRY;
                end
            end
            S_PROGRAM: begin
                if (c_pulse) begin
                    state_n  = S_OPEN;
                    idx_n    = '0;
                    shadow_n = '0;
                end else if (e_pulse) begin
                    shadow_n[idx*DIG_W +: DIG_W] = switch;
                    if (last_digit) begin
                        code_n  = shadow_n;
                        idx_n   = '0;
                        state_n = S_ENTRY;
                    end else begin
                        idx_n = idx + IW'(1);
                    end
                end
            end
            S_LOCKOUT: begin
                if (lock_tmr == '0) begin
                    state_n = S_ENTRY;
                end else begin
                    lock_tmr_n = lock_tmr - LW'(1);
                end
            end
            S_ALARM: begin
                state_n = S_ALARM;
            end
            default: begin
                state_n = S_ALARM;
            end
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            state     <= S_ENTRY;
            code      <= DEFAULT_CODE;
            shadow    <= '0;
            idx       <= '0;
            mismatch  <= 1'b0;
            tries     <= TRW'(MAX_TRIES);
            lock_tmr  <= '0;
            idle_tmr  <= '0;
            unlock    <= 1'b0;
            prog_mode <= 1'b0;
            lockout   <= 1'b0;
            alarm     <= 1'b0;
            leds      <= 7'b1111110;
        end else begin
            state     <= state_n;
            code      <= code_n;
            shadow    <= shadow_n;
            idx       <= idx_n;
            mismatch  <= mismatch_n;
            tries     <= tries_n;
            lock_tmr  <= lock_tmr_n;
            idle_tmr  <= idle_tmr_n;
            unlock    <= (state_n == S_OPEN);
            prog_mode <= (state_n == S_PROGRAM);
            lockout   <= (state_n == S_LOCKOUT);
            alarm     <= (state_n == S_ALARM);
            leds      <= led_pattern(state_n);
        end
    end

    assign digit_idx  = idx;
    assign tries_left = tries;

endmodule
